// File: rtl/alu_muldiv_pkg.sv
// Shared encodings and helpers for the sequential multiply/divide engine.
// Imported by the interface-facing top and its step datapath.
package alu_muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MULS = 2'b01,
      OP_DIV  = 2'b10,
      OP_MOD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PREP = 2'b01,
      ST_RUN  = 2'b10,
      ST_FIX  = 2'b11
   } state_e;

   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bundle between the ALU top and the multiply/divide engine.
// The abort input exists only when ALU_MULDIV_ABORT_EN is defined.
interface alu_muldiv_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_high;
   logic             Z;
   logic             N;
   logic             C;
   logic             V;
   logic             div_by_zero;

`ifdef ALU_MULDIV_ABORT_EN
   logic             abort;

   modport master (
      output start, op, A, B, abort,
      input  busy, done, result, result_high, Z, N, C, V, div_by_zero
   );

   modport slave (
      input  start, op, A, B, abort,
      output busy, done, result, result_high, Z, N, C, V, div_by_zero
   );
`else
   modport master (
      output start, op, A, B,
      input  busy, done, result, result_high, Z, N, C, V, div_by_zero
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, result, result_high, Z, N, C, V, div_by_zero
   );
`endif

endinterface

// File: rtl/alu_muldiv_step.sv
// One iteration of the engine: shift-add for multiply, restoring shift-subtract
// for divide. lo_o leaves the new quotient bit clear; it is reported on qbit_o.
module alu_muldiv_step #(
   parameter int WIDTH = 16
) (
   input  logic             div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             qbit_o
);
   logic [WIDTH:0] addSum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // Borrow out of the trial subtract (diff MSB) means the divisor did not fit.
   always_comb begin
      addSum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});
      trial  = {hi_i, lo_i[WIDTH-1]};
      diff   = trial - {1'b0, m_i};
      hi_o   = '0;
      lo_o   = '0;
      qbit_o = 1'b0;
      if (div_i) begin
         qbit_o = ~diff[WIDTH];
         hi_o   = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_o   = {lo_i[WIDTH-2:0], 1'b0};
      end else begin
         hi_o   = addSum[WIDTH:1];
         lo_o   = {addSum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULU/MULS/DIV/MOD engine with fixed latency WIDTH/UNROLL+2.
// Define ALU_MULDIV_ABORT_EN to add an abort input that cancels a running op.
module alu_muldiv_seq
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int UNROLL = 1
) (
   input logic             clk,
   input logic             rst,
   alu_muldiv_seq_if.slave bus
);
   localparam int STEPS = WIDTH / UNROLL;
   localparam int CNT_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] a_q, b_q, m_q, hi_q, lo_q;
   logic             neg_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q, z_q, n_q, c_q, v_q, dbz_q;
   logic [WIDTH-1:0] result_q, result_high_q;
   logic             abortReq;

`ifdef ALU_MULDIV_ABORT_EN
   assign abortReq = bus.abort;
`else
   assign abortReq = 1'b0;
`endif

   logic             signedOp, aNeg, bNeg, negD;
   logic [WIDTH-1:0] absA, absB;

   assign signedOp = (op_q != OP_MULU);
   assign aNeg     = signedOp & a_q[WIDTH-1];
   assign bNeg     = signedOp & b_q[WIDTH-1];
   assign absA     = aNeg ? -a_q : a_q;
   assign absB     = bNeg ? -b_q : b_q;
   assign negD     = (op_q == OP_MOD) ? aNeg : (aNeg ^ bNeg);

   logic [WIDTH-1:0] hiChain [UNROLL+1];
   logic [WIDTH-1:0] loChain [UNROLL+1];
   logic [WIDTH-1:0] loShift [UNROLL];
   logic             qBit    [UNROLL];

   assign hiChain[0] = hi_q;
   assign loChain[0] = lo_q;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
         .div_i  (op_q[1]),
         .hi_i   (hiChain[g]),
         .lo_i   (loChain[g]),
         .m_i    (m_q),
         .hi_o   (hiChain[g+1]),
         .lo_o   (loShift[g]),
         .qbit_o (qBit[g])
      );
      assign loChain[g+1] = loShift[g] | WIDTH'(qBit[g]);
   end

   logic [2*WIDTH-1:0] prodMag, prodSigned;
   logic [WIDTH-1:0]   resD, resHighD;
   logic               zD, nD, cD, vD, dbzD;

   // Sign correction and flag derivation from the unsigned magnitudes in hi_q/lo_q.
   always_comb begin
      prodMag    = {hi_q, lo_q};
      prodSigned = neg_q ? -prodMag : prodMag;
      resD       = '0;
      resHighD   = '0;
      nD         = 1'b0;
      cD         = 1'b0;
      vD         = 1'b0;
      dbzD       = 1'b0;
      case (op_q)
         OP_MULU: begin
            {resHighD, resD} = prodMag;
            cD = |resHighD;
            vD = cD;
         end
         OP_MULS: begin
            {resHighD, resD} = prodSigned;
            nD = resHighD[WIDTH-1];
            cD = (resHighD != {WIDTH{resD[WIDTH-1]}});
            vD = cD;
         end
         OP_DIV: begin
            if (b_q == '0) begin
               resD = '1;
               vD   = 1'b1;
               dbzD = 1'b1;
            end else begin
               resD = neg_q ? -lo_q : lo_q;
               vD   = (a_q == MIN_VAL) && (b_q == '1);
            end
         end
         OP_MOD: begin
            if (b_q == '0) begin
               resD = a_q;
               vD   = 1'b1;
               dbzD = 1'b1;
            end else begin
               resD = neg_q ? -hi_q : hi_q;
            end
         end
      endcase
      if (op_q[1]) nD = resD[WIDTH-1];
      zD = ({resHighD, resD} == '0);
   end

   // Abort only matters outside IDLE; in FIX it wins over committing results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_MULU;
         a_q           <= '0;
         b_q           <= '0;
         m_q           <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         neg_q         <= 1'b0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         result_q      <= '0;
         result_high_q <= '0;
         z_q           <= 1'b0;
         n_q           <= 1'b0;
         c_q           <= 1'b0;
         v_q           <= 1'b0;
         dbz_q         <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abortReq && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.start) begin
                     a_q     <= bus.A;
                     b_q     <= bus.B;
                     op_q    <= op_e'(bus.op);
                     busy_q  <= 1'b1;
                     state_q <= ST_PREP;
                  end
               end
               ST_PREP: begin
                  hi_q    <= '0;
                  lo_q    <= absA;
                  m_q     <= absB;
                  neg_q   <= negD;
                  cnt_q   <= CNT_LOAD;
                  state_q <= ST_RUN;
               end
               ST_RUN: begin
                  hi_q  <= hiChain[UNROLL];
                  lo_q  <= loChain[UNROLL];
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == '0) state_q <= ST_FIX;
               end
               ST_FIX: begin
                  result_q      <= resD;
                  result_high_q <= resHighD;
                  z_q           <= zD;
                  n_q           <= nD;
                  c_q           <= cD;
                  v_q           <= vD;
                  dbz_q         <= dbzD;
                  done_q        <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.result_high = result_high_q;
   assign bus.Z           = z_q;
   assign bus.N           = n_q;
   assign bus.C           = c_q;
   assign bus.V           = v_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq (WIDTH=16, UNROLL=1, latency 18),
// comparing against an integer-arithmetic reference model.
module tb_alu_muldiv_seq;
   import alu_muldiv_pkg::*;

   localparam int W   = 16;
   localparam int LAT = W + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alu_muldiv_seq_if #(.WIDTH(W)) bus ();

   alu_muldiv_seq #(.WIDTH(W), .UNROLL(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Observation vector: {busy, result, result_high, Z, N, C, V, div_by_zero}
   logic [37:0] obs;
   assign obs = {bus.busy, bus.result, bus.result_high, bus.Z, bus.N, bus.C, bus.V, bus.div_by_zero};

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] hi;
      logic [4:0]  flags;
   } vec_t;

   // Reference model from plain signed/unsigned integer arithmetic.
   function automatic logic [37:0] refModel(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      int          sa, sb, q, r;
      longint      p;
      logic [15:0] res, hi;
      logic        z, n, c, v, d;
      sa = $signed(a);
      sb = $signed(b);
      res = '0; hi = '0; c = 1'b0; v = 1'b0; d = 1'b0; n = 1'b0;
      p = 0;
      case (op)
         2'd0: begin
            p = longint'(a) * longint'(b);
            {hi, res} = p[31:0];
            c = (hi != 0);
            v = c;
         end
         2'd1: begin
            p = longint'(sa) * longint'(sb);
            {hi, res} = p[31:0];
            v = (p < -32768) || (p > 32767);
            c = v;
            n = hi[15];
         end
         2'd2: begin
            if (b == 0) begin
               res = 16'hFFFF; v = 1'b1; d = 1'b1;
            end else if (sa == -32768 && sb == -1) begin
               res = 16'h8000; v = 1'b1;
            end else begin
               q = sa / sb;
               res = q[15:0];
            end
            n = res[15];
         end
         default: begin
            if (b == 0) begin
               res = a; v = 1'b1; d = 1'b1;
            end else begin
               r = sa % sb;
               res = r[15:0];
            end
            n = res[15];
         end
      endcase
      z = ({hi, res} == 32'd0);
      return {1'b0, res, hi, z, n, c, v, d};
   endfunction

   function automatic logic [15:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         3:       return 16'h0001;
         default: return 16'($urandom());
      endcase
   endfunction

   // Issue one request and wait for done; lat is -1 if done never arrives.
   task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output int lat, output logic [37:0] snap, output logic doneAfter);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat  = -1;
      snap = obs;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat  = cyc;
            snap = obs;
            break;
         end
      end
      @(posedge clk);
      #1 doneAfter = bus.done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (obs !== 38'h0) begin
         bad++;
         $display("[TB] FAIL reset_state: got %h want %h", obs, 38'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== 38'h0 || bus.done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release: got %h done=%b want %h done=0", obs, bus.done, 38'h0);
      end
   endtask

   task automatic test_directed();
      vec_t        vecs [9];
      int          lat;
      logic [37:0] snap, want;
      logic        dAfter;
      vecs[0] = '{2'd1, 16'hFFF5, 16'h0005, 16'hFFC9, 16'hFFFF, 5'b01000};
      vecs[1] = '{2'd2, 16'hFFEC, 16'h0005, 16'hFFFC, 16'h0000, 5'b01000};
      vecs[2] = '{2'd3, 16'hFFF8, 16'h0003, 16'hFFFE, 16'h0000, 5'b01000};
      vecs[3] = '{2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00110};
      vecs[4] = '{2'd2, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 5'b01010};
      vecs[5] = '{2'd2, 16'h0007, 16'h0000, 16'hFFFF, 16'h0000, 5'b01011};
      vecs[6] = '{2'd3, 16'h0007, 16'h0000, 16'h0007, 16'h0000, 5'b00011};
      vecs[7] = '{2'd3, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 5'b10000};
      vecs[8] = '{2'd0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 5'b10000};
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, snap, dAfter);
         want = {1'b0, vecs[i].res, vecs[i].hi, vecs[i].flags};
         total++;
         if (lat !== LAT) begin
            bad++;
            $display("[TB] FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT);
         end
         total++;
         if (snap !== want) begin
            bad++;
            $display("[TB] FAIL directed_result[%0d]: got %h want %h", i, snap, want);
         end
         total++;
         if (dAfter !== 1'b0) begin
            bad++;
            $display("[TB] FAIL directed_done_pulse[%0d]: got %b want 0", i, dAfter);
         end
      end
   endtask

   task automatic test_start_ignored();
      int          doneCount, firstDone;
      logic [37:0] snap, want;
      want = refModel(2'd2, 16'h0007, 16'h0000);
      snap = '0;
      doneCount = 0;
      firstDone = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'd2; bus.A = 16'h0007; bus.B = 16'h0000;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            doneCount++;
            if (firstDone < 0) begin
               firstDone = cyc;
               snap = obs;
            end
         end
         if (cyc == 5) begin
            total++;
            if (bus.busy !== 1'b1) begin
               bad++;
               $display("[TB] FAIL busy_during_run: got %b want 1", bus.busy);
            end
            bus.start = 1'b1; bus.op = 2'd0; bus.A = 16'h0003; bus.B = 16'h0003;
         end
         if (cyc == 6) bus.start = 1'b0;
      end
      total++;
      if (doneCount !== 1 || firstDone !== LAT) begin
         bad++;
         $display("[TB] FAIL start_ignored: got dones=%0d at %0d want dones=1 at %0d", doneCount, firstDone, LAT);
      end
      total++;
      if (snap !== want) begin
         bad++;
         $display("[TB] FAIL div_by_zero_result: got %h want %h", snap, want);
      end
   endtask

   task automatic test_reset_midrun();
      int          doneCount, lat;
      logic [37:0] snap, want;
      logic        dAfter;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'd2; bus.A = 16'h1234; bus.B = 16'h0007;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (obs !== 38'h0) begin
         bad++;
         $display("[TB] FAIL async_reset_midrun: got %h want %h", obs, 38'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      doneCount = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.done) doneCount++;
      end
      total++;
      if (doneCount !== 0) begin
         bad++;
         $display("[TB] FAIL no_done_after_reset: got %0d want 0", doneCount);
      end
      applyStimulus(2'd1, 16'h0123, 16'hFF00, lat, snap, dAfter);
      want = refModel(2'd1, 16'h0123, 16'hFF00);
      total++;
      if (lat !== LAT || snap !== want) begin
         bad++;
         $display("[TB] FAIL restart_after_reset: got lat=%0d %h want lat=%0d %h", lat, snap, LAT, want);
      end
   endtask

   task automatic test_back_to_back();
      int          lat, firstDone;
      logic [37:0] snap, want1, want2, got2;
      logic        dAfter;
      want1 = refModel(2'd3, 16'h8001, 16'h0007);
      want2 = refModel(2'd0, 16'hABCD, 16'h1357);
      applyStimulus(2'd3, 16'h8001, 16'h0007, lat, snap, dAfter);
      total++;
      if (lat !== LAT || snap !== want1) begin
         bad++;
         $display("[TB] FAIL b2b_first: got lat=%0d %h want lat=%0d %h", lat, snap, LAT, want1);
      end
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'd0; bus.A = 16'hABCD; bus.B = 16'h1357;
      @(posedge clk);
      #1 bus.start = 1'b0;
      firstDone = -1;
      got2 = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 9) begin
            total++;
            if (obs[36:0] !== want1[36:0]) begin
               bad++;
               $display("[TB] FAIL result_hold: got %h want %h", obs[36:0], want1[36:0]);
            end
         end
         if (bus.done) begin
            firstDone = cyc;
            got2 = obs;
            break;
         end
      end
      total++;
      if (firstDone !== LAT || got2 !== want2) begin
         bad++;
         $display("[TB] FAIL b2b_second: got lat=%0d %h want lat=%0d %h", firstDone, got2, LAT, want2);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int          lat;
      logic [1:0]  op;
      logic [15:0] a, b;
      logic [37:0] snap, want;
      logic        dAfter;
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pickOperand();
         b  = pickOperand();
         want = refModel(op, a, b);
         applyStimulus(op, a, b, lat, snap, dAfter);
         total++;
         if (lat !== LAT || snap !== want) begin
            bad++;
            $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d %h want lat=%0d %h",
                     i, op, a, b, lat, snap, LAT, want);
         end
      end
   endtask

`ifdef ALU_MULDIV_ABORT_EN
   task automatic test_abort();
      int          lat, doneCount;
      logic [37:0] snap, prior, want;
      logic        dAfter;
      prior = refModel(2'd0, 16'h0101, 16'h0003);
      applyStimulus(2'd0, 16'h0101, 16'h0003, lat, snap, dAfter);
      total++;
      if (snap !== prior) begin
         bad++;
         $display("[TB] FAIL abort_setup: got %h want %h", snap, prior);
      end
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'd2; bus.A = 16'h7777; bus.B = 16'h0005;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || obs !== prior) begin
         bad++;
         $display("[TB] FAIL abort_run: got busy=%b done=%b %h want busy=0 done=0 %h", bus.busy, bus.done, obs, prior);
      end
      bus.abort = 1'b0;
      doneCount = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.done) doneCount++;
      end
      total++;
      if (doneCount !== 0) begin
         bad++;
         $display("[TB] FAIL abort_no_done: got %0d want 0", doneCount);
      end
      want = refModel(2'd3, 16'hF00F, 16'h0011);
      applyStimulus(2'd3, 16'hF00F, 16'h0011, lat, snap, dAfter);
      total++;
      if (lat !== LAT || snap !== want) begin
         bad++;
         $display("[TB] FAIL abort_restart: got lat=%0d %h want lat=%0d %h", lat, snap, LAT, want);
      end
   endtask
`endif

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.A     = '0;
      bus.B     = '0;
`ifdef ALU_MULDIV_ABORT_EN
      bus.abort = 1'b0;
`endif
      test_reset();
      test_directed();
      test_start_ignored();
      test_reset_midrun();
      test_back_to_back();
      test_random();
`ifdef ALU_MULDIV_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
